// File: rtl/io_bridge.sv
// io_bridge: memory-mapped I/O slave on the CPU bus (cpu_a[17:16] == 2'b11).
//   0x30000 write : push non-zero byte into the TX FIFO (zero bytes ignored)
//   0x30004 write : push 0x00 terminator and start the program-stop sequence
//   0x30000 read  : UART RX byte (0x00 when none), pulses rx_pop
//   0x30004 read  : snapshot cycle counter, return byte 0; 0x30005..7 bytes 1..3
// Ports:
//   clk_in, rst_in (async, active-high), rdy_in (bus qualifier)
//   cpu_a/cpu_dout/cpu_wr in, cpu_din/io_rd_sel_q/io_buffer_full out
//   tx_data/tx_valid out, tx_ready in (FIFO head toward UART TX)
//   rx_data/rx_valid in, rx_pop out (UART RX consume pulse)
//   tx_overflow (sticky), program_done (stop sequence finished)
// Optional feature macro: IO_CYCLE_COUNTER_EN builds the 32-bit cycle counter
// and its read snapshot; without it 0x30004..0x30007 read as 0x00.
module io_bridge #(
  parameter int unsigned FIFO_DEPTH_LOG2 = 4,
  parameter int unsigned FULL_MARGIN     = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] cpu_a,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_wr,
  output logic [7:0]  cpu_din,
  output logic        io_rd_sel_q,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_pop,
  output logic        tx_overflow,
  output logic        program_done
);

  localparam int unsigned DEPTH       = 1 << FIFO_DEPTH_LOG2;
  localparam int unsigned PW          = FIFO_DEPTH_LOG2;
  localparam int unsigned CW          = FIFO_DEPTH_LOG2 + 1;
  localparam int unsigned FULL_THRESH = DEPTH - FULL_MARGIN;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_STOPPING = 2'd1,
    ST_DONE     = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    cpu_din_q;
  logic          io_buffer_full_q;
  logic          tx_overflow_q;

  logic          io_acc, wr_en, rd_en;
  logic [2:0]    off;
  logic          fifo_full, pop, push_req, push, ovf;
  logic          wr_tx, wr_stop;
  logic [7:0]    push_data;
  logic [7:0]    rd_data;

  // Upper address bits are not decoded.
  logic unused_addr;
  assign unused_addr = ^{cpu_a[31:18], cpu_a[15:3]};

`ifdef IO_CYCLE_COUNTER_EN
  logic [31:0] cyc_q;
  logic [31:0] snap_q;
`endif

  // Bus decode and FIFO push/pop qualification
  always_comb begin
    io_acc    = rdy_in && (cpu_a[17:16] == 2'b11);
    off       = cpu_a[2:0];
    wr_en     = io_acc && cpu_wr && (state_q == ST_RUN);
    rd_en     = io_acc && !cpu_wr;
    fifo_full = (count_q == CW'(DEPTH));
    pop       = (count_q != '0) && tx_ready;
    wr_tx     = wr_en && (off == 3'd0) && (cpu_dout != 8'h00);
    wr_stop   = wr_en && (off == 3'd4);
    push_req  = wr_tx || wr_stop;
    push_data = wr_stop ? 8'h00 : cpu_dout;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    push      = push_req && (!fifo_full || pop);
    ovf       = push_req && fifo_full && !pop;
  end

  // Occupancy next-state; also drives io_buffer_full and the stop handshake
  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CW'(1);
    end
  end

  // Stop sequence: DONE once the terminator has been taken by the UART
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:      if (wr_stop) state_d = ST_STOPPING;
      ST_STOPPING: if (count_d == '0) state_d = ST_DONE;
      ST_DONE:     state_d = ST_DONE;
      default:     state_d = ST_RUN;
    endcase
  end

  // Read data mux
  always_comb begin
    rd_data = 8'h00;
    unique case (off)
      3'd0: rd_data = rx_valid ? rx_data : 8'h00;
`ifdef IO_CYCLE_COUNTER_EN
      3'd4: rd_data = cyc_q[7:0];
      3'd5: rd_data = snap_q[15:8];
      3'd6: rd_data = snap_q[23:16];
      3'd7: rd_data = snap_q[31:24];
`endif
      default: rd_data = 8'h00;
    endcase
  end

  // Control/status registers and FSM
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q          <= ST_RUN;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      cpu_din_q        <= 8'h00;
      io_rd_sel_q      <= 1'b0;
      io_buffer_full_q <= 1'b0;
      tx_overflow_q    <= 1'b0;
    end else begin
      state_q          <= state_d;
      count_q          <= count_d;
      io_rd_sel_q      <= rd_en;
      io_buffer_full_q <= (count_d >= CW'(FULL_THRESH));
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (ovf)  tx_overflow_q <= 1'b1;
      if (rd_en) cpu_din_q <= rd_data;
    end
  end

  // FIFO storage; contents are don't-care while the slot is empty
  always_ff @(posedge clk_in) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

`ifdef IO_CYCLE_COUNTER_EN
  // Free-running cycle counter and read snapshot
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cyc_q  <= 32'd0;
      snap_q <= 32'd0;
    end else begin
      cyc_q <= cyc_q + 32'd1;
      if (rd_en && (off == 3'd4)) snap_q <= cyc_q;
    end
  end
`endif

  // Head byte is masked while empty so the output is defined after reset
  assign tx_valid       = (count_q != '0);
  assign tx_data        = tx_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign rx_pop         = rd_en && (off == 3'd0) && rx_valid;
  assign cpu_din        = cpu_din_q;
  assign io_buffer_full = io_buffer_full_q;
  assign tx_overflow    = tx_overflow_q;
  assign program_done   = (state_q == ST_DONE);

endmodule

// File: tb/tb_io_bridge.sv
// tb_io_bridge: directed self-checking bench for io_bridge (depth 16, margin 2).
module tb_io_bridge;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b0;
  logic [31:0] cpu_a = 32'd0;
  logic [7:0]  cpu_dout = 8'h00;
  logic        cpu_wr = 1'b0;
  logic [7:0]  cpu_din;
  logic        io_rd_sel_q;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_pop;
  logic        tx_overflow;
  logic        program_done;

  int checks = 0;
  int failures = 0;

  io_bridge #(.FIFO_DEPTH_LOG2(4), .FULL_MARGIN(2)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .cpu_a(cpu_a), .cpu_dout(cpu_dout), .cpu_wr(cpu_wr),
    .cpu_din(cpu_din), .io_rd_sel_q(io_rd_sel_q), .io_buffer_full(io_buffer_full),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_pop(rx_pop),
    .tx_overflow(tx_overflow), .program_done(program_done)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic bus(input logic [17:0] a, input logic wr, input logic [7:0] d);
    rdy_in   = 1'b1;
    cpu_a    = {14'h0, a};
    cpu_wr   = wr;
    cpu_dout = d;
  endtask

  task automatic bus_idle();
    rdy_in   = 1'b0;
    cpu_a    = 32'd0;
    cpu_wr   = 1'b0;
    cpu_dout = 8'h00;
  endtask

  // Leaves the bench at a negedge with reset just released.
  task automatic do_reset();
    bus_idle();
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    rst_in   = 1'b1;
    repeat (2) @(negedge clk_in);
    rst_in   = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_b;
    logic [7:0] drain [4];
    drain[0] = 8'h11; drain[1] = 8'h22; drain[2] = 8'h33; drain[3] = 8'h00;

    // Reset values
    repeat (2) @(negedge clk_in);
    chk("rst_cpu_din", 32'(cpu_din), 32'h0);
    chk("rst_rd_sel", 32'(io_rd_sel_q), 32'h0);
    chk("rst_full", 32'(io_buffer_full), 32'h0);
    chk("rst_tx_valid", 32'(tx_valid), 32'h0);
    chk("rst_tx_data", 32'(tx_data), 32'h0);
    chk("rst_ovf", 32'(tx_overflow), 32'h0);
    chk("rst_done", 32'(program_done), 32'h0);
    rst_in = 1'b0;
    @(negedge clk_in);

    // Zero filter and head order with UART always ready
    tx_ready = 1'b1;
    bus(18'h30000, 1'b1, 8'h41); @(negedge clk_in);
    chk("t1_valid41", 32'(tx_valid), 32'h1);
    chk("t1_data41", 32'(tx_data), 32'h41);
    bus(18'h30000, 1'b1, 8'h42); @(negedge clk_in);
    chk("t1_data42", 32'(tx_data), 32'h42);
    bus(18'h30000, 1'b1, 8'h00); @(negedge clk_in);
    chk("t1_zero_dropped", 32'(tx_valid), 32'h0);
    // Access with rdy_in low is ignored
    bus(18'h30000, 1'b1, 8'h99); rdy_in = 1'b0; @(negedge clk_in);
    chk("t1_rdy_low", 32'(tx_valid), 32'h0);
    bus_idle();

    // Fill to 16 with UART stalled; full flag from the 14th write on
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      bus(18'h30000, 1'b1, 8'h55); @(negedge clk_in);
      chk($sformatf("t2_full_w%0d", k), 32'(io_buffer_full), (k >= 14) ? 32'h1 : 32'h0);
    end
    chk("t2_no_ovf_at16", 32'(tx_overflow), 32'h0);
    bus(18'h30000, 1'b1, 8'h55); @(negedge clk_in);
    chk("t2_ovf_w17", 32'(tx_overflow), 32'h1);
    bus_idle();

    // Asynchronous reset flushes the FIFO
    rst_in = 1'b1; #1;
    chk("t3_async_flush", 32'(tx_valid), 32'h0);
    chk("t3_async_ovf", 32'(tx_overflow), 32'h0);

    // Full FIFO with simultaneous push and pop for 40 cycles
    do_reset();
    for (int k = 0; k < 16; k++) begin
      bus(18'h30000, 1'b1, 8'h55); @(negedge clk_in);
    end
    tx_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      exp_b = (i < 16) ? 8'h55 : 8'(8'h60 + i - 16);
      chk($sformatf("t3_head%0d", i), 32'(tx_data), 32'(exp_b));
      bus(18'h30000, 1'b1, 8'(8'h60 + i)); @(negedge clk_in);
    end
    chk("t3_full_held", 32'(io_buffer_full), 32'h1);
    chk("t3_no_ovf", 32'(tx_overflow), 32'h0);
    bus_idle();
    for (int j = 0; j < 16; j++) begin
      chk($sformatf("t3_drain%0d", j), 32'(tx_data), 32'(8'(8'h60 + 24 + j)));
      @(negedge clk_in);
    end
    chk("t3_empty", 32'(tx_valid), 32'h0);
    chk("t3_not_full", 32'(io_buffer_full), 32'h0);

    // UART RX reads
    rx_valid = 1'b0;
    bus(18'h30000, 1'b0, 8'h00); #1;
    chk("t4_no_pop", 32'(rx_pop), 32'h0);
    @(negedge clk_in);
    chk("t4_din_empty", 32'(cpu_din), 32'h0);
    chk("t4_sel_empty", 32'(io_rd_sel_q), 32'h1);
    rx_valid = 1'b1; rx_data = 8'h7A;
    bus(18'h30000, 1'b0, 8'h00); #1;
    chk("t4_pop", 32'(rx_pop), 32'h1);
    @(negedge clk_in);
    rx_valid = 1'b0;
    bus_idle(); #1;
    chk("t4_pop_once", 32'(rx_pop), 32'h0);
    chk("t4_din_7a", 32'(cpu_din), 32'h7A);
    chk("t4_sel", 32'(io_rd_sel_q), 32'h1);
    @(negedge clk_in);
    chk("t4_din_hold", 32'(cpu_din), 32'h7A);
    chk("t4_sel_clear", 32'(io_rd_sel_q), 32'h0);
    bus(18'h30001, 1'b0, 8'h00); @(negedge clk_in);
    chk("t4_other_off", 32'(cpu_din), 32'h0);
    bus_idle();

    // Cycle counter snapshot, 100 cycles after reset
    do_reset();
    repeat (100) @(posedge clk_in);
    @(negedge clk_in);
    bus(18'h30004, 1'b0, 8'h00); @(negedge clk_in);
`ifdef IO_CYCLE_COUNTER_EN
    chk("t5_byte0", 32'(cpu_din), 32'h64);
`else
    chk("t5_byte0", 32'(cpu_din), 32'h00);
`endif
    bus(18'h30005, 1'b0, 8'h00); @(negedge clk_in);
    chk("t5_byte1", 32'(cpu_din), 32'h00);
    bus(18'h30006, 1'b0, 8'h00); @(negedge clk_in);
    chk("t5_byte2", 32'(cpu_din), 32'h00);
    bus(18'h30007, 1'b0, 8'h00); @(negedge clk_in);
    chk("t5_byte3", 32'(cpu_din), 32'h00);
    bus_idle();

    // Program-stop sequence
    do_reset();
    bus(18'h30000, 1'b1, 8'h11); @(negedge clk_in);
    bus(18'h30000, 1'b1, 8'h22); @(negedge clk_in);
    bus(18'h30000, 1'b1, 8'h33); @(negedge clk_in);
    bus(18'h30004, 1'b1, 8'h00); @(negedge clk_in);
    bus(18'h30000, 1'b1, 8'h44); @(negedge clk_in);
    bus_idle();
    chk("t6_not_done", 32'(program_done), 32'h0);
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t6_head%0d", i), 32'(tx_data), 32'(drain[i]));
      chk($sformatf("t6_valid%0d", i), 32'(tx_valid), 32'h1);
      chk($sformatf("t6_done_low%0d", i), 32'(program_done), 32'h0);
      @(negedge clk_in);
    end
    chk("t6_done", 32'(program_done), 32'h1);
    chk("t6_drained", 32'(tx_valid), 32'h0);
    bus(18'h30000, 1'b1, 8'h55); @(negedge clk_in);
    chk("t6_done_wr_ignored", 32'(tx_valid), 32'h0);
    bus_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
